// File: rtl/mac_multiplex_result_collector.sv
// -----------------------------------------------------------------------------
// mac_multiplex_result_collector
//
// Output-side companion of the top_mac_multiplex operand driver. It watches the
// same accu_rst / op_valid strobes that feed the MAC. It delays them by the MAC
// pipeline latency so they line up with z. It captures the final accumulated z
// of every accumulation window together with the number of operand cycles in
// that window. Each {z, count} pair is queued in a small first-word-fall-through
// FIFO and offered on a valid/ready result stream.
//
// Ports:
//   clk         in   1            single clock, rising edge
//   rst         in   1            synchronous, active-high reset
//   accu_rst    in   1            accumulator clear (same signal as at the MAC)
//   op_valid    in   1            MAC inputs carry an operand set this cycle
//   z           in   Z_WIDTH      MAC accumulator output, signed
//   res_valid   out  1            FIFO head valid
//   res_ready   in   1            consumer accepts head when res_valid=1
//   res_z       out  Z_WIDTH      final window sum, bit-exact copy of z
//   res_count   out  CNT_WIDTH    operand cycles in the window (saturating)
//   overflow    out  1            sticky: a result was dropped on a full FIFO
//   fifo_level  out  LVL_WIDTH    current FIFO occupancy
// -----------------------------------------------------------------------------
module mac_multiplex_result_collector #(
    parameter int W_WIDTH         = 8,
    parameter int A_WIDTH         = 8,
    parameter int PLUS_WIDTH      = 4,
    parameter int CONFIG_AW_WIDTH = 2,
    parameter int MAC_LATENCY     = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_WIDTH       = 8,
    localparam int Z_WIDTH   = W_WIDTH + A_WIDTH + (2 ** CONFIG_AW_WIDTH) * PLUS_WIDTH,
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH),
    localparam int LVL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        accu_rst,
    input  logic                        op_valid,
    input  logic signed [Z_WIDTH-1:0]   z,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic signed [Z_WIDTH-1:0]   res_z,
    output logic [CNT_WIDTH-1:0]        res_count,
    output logic                        overflow,
    output logic [LVL_WIDTH-1:0]        fifo_level
);

    // One FIFO entry: final window sum plus its operand-cycle count.
    typedef struct packed {
        logic [Z_WIDTH-1:0]   z;
        logic [CNT_WIDTH-1:0] cnt;
    } entry_t;

    // -------------------------------------------------------------------------
    // Strobe delay line: aligns op_valid / accu_rst with the z they affect.
    // Bit 0 is the youngest stage, bit MAC_LATENCY-1 drives the window logic.
    // -------------------------------------------------------------------------
    logic [MAC_LATENCY-1:0] op_dly_q,  op_dly_d;
    logic [MAC_LATENCY-1:0] clr_dly_q, clr_dly_d;
    logic                   d_op;
    logic                   d_clr;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the block can leave it unassigned (no latch).
    always_comb begin
        op_dly_d     = op_dly_q;
        clr_dly_d    = clr_dly_q;
        op_dly_d[0]  = op_valid;
        clr_dly_d[0] = accu_rst;
        for (int i = 1; i < MAC_LATENCY; i++) begin
            op_dly_d[i]  = op_dly_q[i-1];
            clr_dly_d[i] = clr_dly_q[i-1];
        end
    end

    assign d_op  = op_dly_q[MAC_LATENCY-1];
    assign d_clr = clr_dly_q[MAC_LATENCY-1];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_dly_q  <= '0;
            clr_dly_q <= '0;
        end else begin
            op_dly_q  <= op_dly_d;
            clr_dly_q <= clr_dly_d;
        end
    end

    // -------------------------------------------------------------------------
    // Window tracking.
    // z_hold keeps z from the last operand cycle. The MAC may already show a
    // cleared value in the delayed-clear cycle, so z itself is not pushed there.
    // A clear always wins over a coincident operand strobe.
    // -------------------------------------------------------------------------
    logic                 open_q,   open_d;
    logic [CNT_WIDTH-1:0] count_q,  count_d;
    logic [Z_WIDTH-1:0]   z_hold_q, z_hold_d;
    logic                 push;
    entry_t               push_entry;

    always_comb begin
        open_d   = open_q;
        count_d  = count_q;
        z_hold_d = z_hold_q;
        push     = 1'b0;
        if (d_clr) begin
            push    = open_q;
            open_d  = 1'b0;
            count_d = '0;
        end else if (d_op) begin
            z_hold_d = z;
            open_d   = 1'b1;
            // Saturate at all-ones rather than wrapping back to zero.
            if (count_q != '1) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign push_entry = '{z: z_hold_q, cnt: count_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q   <= 1'b0;
            count_q  <= '0;
            z_hold_q <= '0;
        end else begin
            open_q   <= open_d;
            count_q  <= count_d;
            z_hold_q <= z_hold_d;
        end
    end

    // -------------------------------------------------------------------------
    // Result FIFO (first-word-fall-through, no bypass).
    // A push on a full FIFO is accepted only if the head leaves in the same
    // cycle. Otherwise the push is dropped and overflow latches.
    // -------------------------------------------------------------------------
    entry_t               mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q,   rd_ptr_d;
    logic [LVL_WIDTH-1:0] level_q,    level_d;
    logic                 overflow_q, overflow_d;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 wr_en;
    entry_t               head;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_WIDTH'(FIFO_DEPTH));
    assign pop        = !fifo_empty && res_ready;
    assign wr_en      = push && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        // Power-of-two depth: pointers wrap naturally at their width.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
        if (wr_en && !pop) begin
            level_d = level_q + LVL_WIDTH'(1);
        end else if (pop && !wr_en) begin
            level_d = level_q - LVL_WIDTH'(1);
        end
        if (push && !wr_en) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is deliberately left without reset. Only the
    // pointers and level define which entries are meaningful, and the head
    // outputs are masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // The head is read straight from registered storage. It cannot change
    // while it is stalled, because a write never targets the head slot unless
    // the head is popped in the same cycle.
    assign head       = mem_q[rd_ptr_q];
    assign res_valid  = !fifo_empty;
    assign res_z      = res_valid ? head.z   : '0;
    assign res_count  = res_valid ? head.cnt : '0;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_mac_multiplex_result_collector.sv
module tb_mac_multiplex_result_collector;

    localparam int ZW   = 32;
    localparam int CW   = 8;
    localparam int DEPTH = 4;
    localparam int LAT  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 accu_rst;
    logic                 op_valid;
    logic signed [ZW-1:0] z;
    logic                 res_valid;
    logic                 res_ready;
    logic signed [ZW-1:0] res_z;
    logic [CW-1:0]        res_count;
    logic                 overflow;
    logic [2:0]           fifo_level;

    always #5 clk = ~clk;

    mac_multiplex_result_collector dut (
        .clk        (clk),
        .rst        (rst),
        .accu_rst   (accu_rst),
        .op_valid   (op_valid),
        .z          (z),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_z      (res_z),
        .res_count  (res_count),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    // Reference model: window sums computed from the operands themselves, a
    // list of closed windows waiting out the MAC latency, and a bounded queue
    // standing in for the result FIFO.
    typedef struct {
        logic [ZW-1:0] z;
        int            cnt;
    } res_t;

    typedef struct {
        logic [ZW-1:0] z;
        int            cnt;
        int            due;
    } pend_t;

    res_t  mq[$];
    pend_t pq[$];
    bit    movf;
    int    wsum;
    int    wcnt;

    // Behavioural MAC driving z: running sum, visible LAT cycles later.
    int                   acc;
    logic signed [ZW-1:0] zs0, zs1;

    int            n_asserts = 0;
    int            n_fail    = 0;
    int            cyc       = 0;
    bit            checking  = 0;
    bit            after_rst = 0;

    // Observations taken from the DUT's result stream.
    int            npop_dut     = 0;
    int            valid_cycles = 0;
    logic [ZW-1:0] last_z_dut;
    logic [CW-1:0] last_cnt_dut;
    int            base_pop;
    int            base_vc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare the current outputs against the
    // model, then advance the model across the coming rising edge.
    task automatic tick(input bit r, input bit op, input bit clr, input int w, input int a,
                        input bit rdy);
        int    p;
        pend_t pp;
        res_t  e;
        p        = w * a;
        rst      = r;
        accu_rst = clr;
        op_valid = op;
        res_ready = rdy;
        z        = zs1;

        if (checking) begin
            chk("res_valid",  {31'd0, res_valid}, {31'd0, mq.size() > 0});
            chk("fifo_level", {29'd0, fifo_level}, mq.size());
            chk("overflow",   {31'd0, overflow},  {31'd0, movf});
            if (mq.size() > 0) begin
                chk("res_z",     $unsigned(res_z), mq[0].z);
                chk("res_count", {24'd0, res_count}, mq[0].cnt);
            end else if (after_rst) begin
                chk("reset res_z",     $unsigned(res_z), 32'd0);
                chk("reset res_count", {24'd0, res_count}, 32'd0);
            end
            if (res_valid === 1'b1) begin
                valid_cycles++;
                if (rdy) begin
                    npop_dut++;
                    last_z_dut   = res_z;
                    last_cnt_dut = res_count;
                end
            end
        end

        if (r) begin
            mq.delete();
            pq.delete();
            movf      = 1'b0;
            wsum      = 0;
            wcnt      = 0;
            acc       = 0;
            checking  = 1'b1;
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (mq.size() > 0 && rdy) begin
                e = mq.pop_front();
            end
            if (pq.size() > 0 && pq[0].due == cyc) begin
                pp = pq.pop_front();
                if (mq.size() < DEPTH) mq.push_back('{z: pp.z, cnt: pp.cnt});
                else                   movf = 1'b1;
            end
            if (clr) begin
                if (wcnt > 0) pq.push_back('{z: wsum, cnt: wcnt, due: cyc + LAT});
                wsum = 0;
                wcnt = 0;
                acc  = 0;
            end else if (op) begin
                wsum += p;
                if (wcnt < 255) wcnt++;
                acc += p;
            end
        end
        zs1 = zs0;
        zs0 = acc;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) tick(1'b0, 1'b0, 1'b0, 0, 0, rdy);
    endtask

    task automatic clear(input bit rdy);
        tick(1'b0, 1'b0, 1'b1, 0, 0, rdy);
    endtask

    // accu_rst followed by nops operand cycles (unit or random signed operands).
    task automatic window(input int nops, input bit rnd, input bit rdy);
        int w;
        int a;
        clear(rdy);
        for (int i = 0; i < nops; i++) begin
            if (rnd) begin
                w = int'($urandom_range(0, 255)) - 128;
                a = int'($urandom_range(0, 255)) - 128;
            end else begin
                w = 1;
                a = 1;
            end
            tick(1'b0, 1'b1, 1'b0, w, a, rdy);
        end
    endtask

    initial begin
        rst = 1'b1; accu_rst = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
        z = '0; zs0 = '0; zs1 = '0; acc = 0;

        // Reset state.
        tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("reset valid", {31'd0, res_valid}, 32'd0);
        chk("reset level", {29'd0, fifo_level}, 32'd0);
        chk("reset overflow", {31'd0, overflow}, 32'd0);

        // Single unit-operand window of 50 ops.
        base_pop = npop_dut;
        base_vc  = valid_cycles;
        window(50, 1'b0, 1'b1);
        clear(1'b1);
        idle(6, 1'b1);
        chk("t1 result count",  npop_dut - base_pop, 32'd1);
        chk("t1 res_z",         last_z_dut, 32'd50);
        chk("t1 res_count",     {24'd0, last_cnt_dut}, 32'd50);
        chk("t1 valid cycles",  valid_cycles - base_vc, 32'd1);

        // Ten back-to-back random signed windows.
        base_pop = npop_dut;
        repeat (10) window(50, 1'b1, 1'b1);
        clear(1'b1);
        idle(6, 1'b1);
        chk("t2 result count", npop_dut - base_pop, 32'd10);
        chk("t2 last count",   {24'd0, last_cnt_dut}, 32'd50);

        // Stalled consumer: five short windows overflow a depth-4 FIFO.
        repeat (5) window(3, 1'b1, 1'b0);
        clear(1'b0);
        idle(4, 1'b0);
        chk("t3 level full", {29'd0, fifo_level}, 32'd4);
        chk("t3 overflow",   {31'd0, overflow},   32'd1);
        base_pop = npop_dut;
        idle(8, 1'b1);
        chk("t3 drained", npop_dut - base_pop, 32'd4);
        tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("t3 overflow cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO with a pop in the same cycle as a new push.
        base_pop = npop_dut;
        repeat (4) window(3, 1'b1, 1'b0);
        clear(1'b0);
        idle(3, 1'b0);
        chk("t4 level full", {29'd0, fifo_level}, 32'd4);
        window(3, 1'b1, 1'b0);
        clear(1'b0);                 // delayed clear pushes two edges later
        idle(1, 1'b0);
        idle(1, 1'b1);               // pop coincides with the push
        idle(1, 1'b0);
        chk("t4 level kept",   {29'd0, fifo_level}, 32'd4);
        chk("t4 no overflow",  {31'd0, overflow},   32'd0);
        idle(8, 1'b1);
        chk("t4 drained", npop_dut - base_pop, 32'd5);

        // Reset in the middle of a window discards it.
        window(20, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
        base_pop = npop_dut;
        window(5, 1'b1, 1'b1);
        clear(1'b1);
        idle(6, 1'b1);
        chk("t5 result count", npop_dut - base_pop, 32'd1);
        chk("t5 res_count",    {24'd0, last_cnt_dut}, 32'd5);

        // Empty window produces nothing; long window saturates the count.
        base_pop = npop_dut;
        clear(1'b1);
        clear(1'b1);
        idle(5, 1'b1);
        chk("t6 empty window", npop_dut - base_pop, 32'd0);
        chk("t6 level",        {29'd0, fifo_level}, 32'd0);
        for (int i = 0; i < 300; i++) tick(1'b0, 1'b1, 1'b0, 1, 1, 1'b1);
        clear(1'b1);
        idle(6, 1'b1);
        chk("t6 result count", npop_dut - base_pop, 32'd1);
        chk("t6 saturated",    {24'd0, last_cnt_dut}, 32'd255);
        chk("t6 res_z",        last_z_dut, 32'd300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_multiplex_result_collector.md
Name: mac_multiplex_result_collector

Overview:
- Output-side counterpart of the operand driver for top_mac_multiplex. It observes the same accu_rst and operand-valid strobes that are driven into the MAC.
- Aligns those strobes to the MAC pipeline latency, captures the final accumulated z of every accumulation window, and tags it with the number of operand cycles.
- Buffers each {z, count} pair in a small FIFO and presents it on a valid/ready result stream, used for gate-level self-checking and result readout.

Parameters:
- W_WIDTH, 8, weight operand width of the MAC.
- A_WIDTH, 8, activation operand width of the MAC.
- PLUS_WIDTH, 4, accumulation guard bits per sub-word.
- CONFIG_AW_WIDTH, 2, precision config width.
- Z_WIDTH, derived: W_WIDTH+A_WIDTH+(2**CONFIG_AW_WIDTH)*PLUS_WIDTH, MAC output width (localparam).
- MAC_LATENCY, 2, cycles from operands applied at the MAC inputs to z including them (>=1).
- FIFO_DEPTH, 4, result entries (power of 2, >=2).
- CNT_WIDTH, 8, operand-cycle counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- accu_rst  in  1  accumulator clear, same signal as driven to the MAC.
- op_valid  in  1  high in cycles where the MAC inputs carry an operand set (rst=0, accu_rst=0).
- z  in  Z_WIDTH  MAC accumulator output, signed.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer accepts head when res_valid=1.
- res_z  out  Z_WIDTH  final window sum, signed, bit-exact copy of z.
- res_count  out  CNT_WIDTH  operand cycles in the window, saturating.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset: rst=1 at a rising edge clears the delay line, window state, FIFO, overflow, res_valid, res_z, res_count and fifo_level to 0. Reset has priority over every other event.
- Delay line: op_valid and accu_rst are delayed by MAC_LATENCY cycles to give d_op and d_clr. The z sampled in a d_op cycle includes that operand set.
- Window state: open flag, count register and z_hold register.
  - d_op=1: z_hold<=z; count<=count+1, saturating at 2**CNT_WIDTH-1; open<=1.
  - d_clr=1 with open=1: push {z_hold, count} to the FIFO, then clear open and count. z_hold is the value captured in the last d_op cycle, not z in the d_clr cycle.
  - d_clr=1 with open=0: no push (empty window).
  - d_op=1 and d_clr=1 in the same cycle: treated as d_clr only; d_op is ignored. This cannot occur with a legal driver.
- Reset mid-window: the open window is discarded and no partial result is pushed. The delay line is also flushed, so strobes in flight are lost.
- FIFO:
  - First-word-fall-through: res_z, res_count and res_valid reflect the head combinationally from registered storage.
  - Pop occurs when res_valid and res_ready are both high.
  - Push while full without a same-cycle pop: the entry is dropped, overflow<=1 (sticky until rst), and the FIFO contents are unchanged.
  - Push while full with a same-cycle pop: the push is accepted and the level stays FIFO_DEPTH.
  - Push while empty: res_valid rises the next cycle. There is no bypass.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level is pushes minus pops.
- res_z and res_count are held stable while res_valid=1 and res_ready=0.
- Arithmetic: no sign extension or truncation. res_z is exactly Z_WIDTH bits of z.

Test Plan:
- MAC_LATENCY=2, one window of 50 operand cycles with w=a=1 (z increments each cycle to 50), res_ready=1 → exactly one result; res_z=50, res_count=50; res_valid high for 1 cycle, 1 cycle after delayed accu_rst.
- Ten back-to-back windows of 50 ops with random signed operands, each preceded by 1 accu_rst cycle → 10 results, res_z equal to the reference-model sums (including negative values), each res_count=50.
- res_ready=0 and 5 windows of 3 ops each → fifo_level=4, overflow=1, and the first 4 sums are preserved in order when res_ready is then raised.
- FIFO full, then res_ready=1 in the same cycle as a new push → level stays 4, overflow stays 0, and the popped and new entries are both correct.
- rst asserted after 20 ops of a window, then released → no result; a subsequent 5-op window gives res_count=5.
- Two consecutive accu_rst cycles with no ops, and 300 ops with CNT_WIDTH=8 → no push for the empty window; res_count saturates at 255.
